mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for a small MIPS subset (FETCH, DCD, EXE, MA, MR, MW, WB, BR, JMP).
// Define MC_CTRL_JAL_EN to add jal (op 000011): JMP also writes PC+4 into $31.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] extOp,
    output logic       BSel,
    output logic [1:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel
);
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_JAL_EN
    localparam logic [5:0] OpJal   = 6'b000011;
`endif
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnSlt   = 6'b101010;

    typedef enum logic [3:0] {
        StFetch, StDcd, StExe, StMa, StMr, StMw, StWb, StBr, StJmp
    } state_t;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       dmwr;
        logic [1:0] extop;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] npcop;
        logic [1:0] gprsel;
        logic [1:0] wdsel;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [5:0] op_q, funct_q;
    logic [5:0] cur_op, cur_funct;

    function automatic logic is_jump(input logic [5:0] o);
`ifdef MC_CTRL_JAL_EN
        return (o == OpJ) || (o == OpJal);
`else
        return o == OpJ;
`endif
    endfunction

    function automatic state_t next_of(input state_t st, input logic [5:0] o);
        state_t n;
        n = StFetch;
        case (st)
            StFetch: n = StDcd;
            StDcd: begin
                if (o == OpRtype || o == OpOri || o == OpLui) n = StExe;
                else if (o == OpLw || o == OpSw)             n = StMa;
                else if (o == OpBeq)                         n = StBr;
                else if (is_jump(o))                         n = StJmp;
                else                                         n = StFetch;
            end
            StExe, StMr: n = StWb;
            StMa:        n = (o == OpLw) ? StMr : StMw;
            default:     n = StFetch;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t st, input logic [5:0] o, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.pcwr = 1'b1;
                c.irwr = 1'b1;
            end
            StExe: begin
                if (o == OpOri) begin
                    c.aluop = 2'b10;
                    c.bsel  = 1'b1;
                end else if (o == OpLui) begin
                    c.extop = 2'b10;
                    c.bsel  = 1'b1;
                end else if (f == FnSubu) begin
                    c.aluop = 2'b01;
                end else if (f == FnSlt) begin
                    c.aluop = 2'b11;
                end
            end
            StMa: begin
                c.extop = 2'b01;
                c.bsel  = 1'b1;
            end
            StMw: c.dmwr = 1'b1;
            StWb: begin
                // Undefined R-type funct walks through WB without writing.
                if (o == OpRtype) begin
                    c.rfwr = (f == FnAddu) || (f == FnSubu) || (f == FnSlt);
                end else begin
                    c.rfwr   = 1'b1;
                    c.gprsel = 2'b01;
                    c.wdsel  = (o == OpLw) ? 2'b01 : 2'b00;
                end
            end
            StBr: begin
                c.aluop = 2'b01;
                c.extop = 2'b01;
                c.npcop = 2'b01;
            end
            StJmp: begin
                c.pcwr  = 1'b1;
                c.npcop = 2'b10;
`ifdef MC_CTRL_JAL_EN
                if (o == OpJal) begin
                    c.rfwr   = 1'b1;
                    c.gprsel = 2'b10;
                    c.wdsel  = 2'b10;
                end
`endif
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // In DCD the IR has just been loaded, so decode from the live inputs; later use the held copy.
    always_comb begin
        cur_op    = (state_q == StDcd) ? op : op_q;
        cur_funct = (state_q == StDcd) ? funct : funct_q;
        state_d   = next_of(state_q, cur_op);
    end

    // Controls are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            ctrl_q  <= decode(StFetch, 6'b0, 6'b0);
            op_q    <= 6'b0;
            funct_q <= 6'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, cur_op, cur_funct);
            if (state_q == StDcd) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        PCWr   = 1'b0;
        IRWr   = 1'b0;
        RFWr   = 1'b0;
        DMWr   = 1'b0;
        extOp  = 2'b00;
        BSel   = 1'b0;
        ALUOp  = 2'b00;
        NPCOp  = 2'b00;
        GPRSel = 2'b00;
        WDSel  = 2'b00;
        if (!rst) begin
            PCWr   = ctrl_q.pcwr | ((state_q == StBr) & zero);
            IRWr   = ctrl_q.irwr;
            RFWr   = ctrl_q.rfwr;
            DMWr   = ctrl_q.dmwr;
            extOp  = ctrl_q.extop;
            BSel   = ctrl_q.bsel;
            ALUOp  = ctrl_q.aluop;
            NPCOp  = ctrl_q.npcop;
            GPRSel = ctrl_q.gprsel;
            WDSel  = ctrl_q.wdsel;
        end
    end
endmodule
